oam_dma_arbiter: RTL and testbench

- Sits between the CPU datapath memory interface (address, RE, WE, byte data) and the single sram port.
- Owns the DMA source register at DMA_REG_ADDR. A write to that register starts a block copy of DMA_LEN bytes from {page, 8'h00} to DMA_DST_BASE.
- While the copy runs, the block arbitrates the sram port between the DMA engine and the CPU. CPU HRAM accesses take priority; every other CPU access is blocked.

---
 rtl/oam_dma_arbiter.sv | 96 +++++++++
 tb/tb_oam_dma_arbiter.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/oam_dma_arbiter.sv
// oam_dma_arbiter: OAM DMA engine that shares the single sram port with the CPU.
// Optional feature macro DMA_CPU_STALL_EN: blocked CPU accesses stall instead of being dropped.
module oam_dma_arbiter #(
    parameter int          DMA_LEN      = 160,
    parameter logic [15:0] DMA_DST_BASE = 16'hFE00,
    parameter logic [15:0] DMA_REG_ADDR = 16'hFF46,
    parameter int          START_DELAY  = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] cpu_addr,
    input  logic        cpu_re,
    input  logic        cpu_we,
    input  logic [7:0]  cpu_wdata,
    output logic [7:0]  cpu_rdata,
    output logic        cpu_stall,
    output logic [15:0] mem_addr,
    output logic        mem_re,
    output logic        mem_we,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    output logic        dma_active
);
    typedef enum logic [1:0] {IDLE, START, READ, WRITE} state_t;
    state_t state, state_nx;
    logic [7:0] page, idx, idx_nx, latch;
    logic [1:0] cnt, cnt_nx;
    logic reg_hit, reg_wr, hram, cpu_win, dma_own;

    assign reg_hit = cpu_addr == DMA_REG_ADDR;
    assign reg_wr = reg_hit && cpu_we;
    assign hram = cpu_addr >= 16'hFF80 && cpu_addr <= 16'hFFFE;
    assign cpu_win = (cpu_re || cpu_we) && (hram || reg_hit);
    // Reset gates DMA off the port in the same cycle so an aborted copy issues no further writes
    assign dma_own = (state == READ || state == WRITE) && !cpu_win && !rst;
    assign dma_active = state != IDLE;

    // Sequencing: any register write restarts, START counts the delay, then READ/WRITE alternate
    always_comb begin
        state_nx = state;
        idx_nx = idx;
        cnt_nx = cnt;
        if (reg_wr) begin
            state_nx = (START_DELAY > 0) ? START : READ;
            idx_nx = '0;
            cnt_nx = '0;
        end else if (state == START) begin
            cnt_nx = cnt + 2'd1;
            if (cnt == 2'(START_DELAY - 1)) state_nx = READ;
        end else if (dma_own) begin
            if (state == READ) state_nx = WRITE;
            else if (idx == 8'(DMA_LEN - 1)) state_nx = IDLE;
            else begin
                idx_nx = idx + 8'd1;
                state_nx = READ;
            end
        end
    end

    // State register; the byte latch loads only on a read cycle the DMA actually owns
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            page <= 8'h00;
            idx <= 8'h00;
            cnt <= 2'd0;
            latch <= 8'h00;
        end else begin
            state <= state_nx;
            idx <= idx_nx;
            cnt <= cnt_nx;
            if (reg_wr) page <= cpu_wdata;
            if (dma_own && state == READ) latch <= mem_rdata;
        end
    end

    // Port mux: CPU pass-through unless the DMA owns this cycle; register accesses never reach sram
    always_comb begin
        mem_addr = cpu_addr;
        mem_re = cpu_re && !reg_hit;
        mem_we = cpu_we && !reg_hit;
        mem_wdata = cpu_wdata;
        cpu_rdata = reg_hit ? page : mem_rdata;
        cpu_stall = 1'b0;
        if (dma_own) begin
            mem_addr = (state == READ) ? {page, idx} : {DMA_DST_BASE[15:8], DMA_DST_BASE[7:0] + idx};
            mem_re = state == READ;
            mem_we = state == WRITE;
            mem_wdata = latch;
            cpu_rdata = 8'hFF;
`ifdef DMA_CPU_STALL_EN
            cpu_stall = cpu_re || cpu_we;
`endif
        end
    end
endmodule

// File: tb/tb_oam_dma_arbiter.sv
// tb_oam_dma_arbiter: bench for oam_dma_arbiter with an sram array, a step-count reference model and directed/random stimulus.
module tb_oam_dma_arbiter;
    localparam int SD = 1;
    localparam int LEN = 160;

    logic clk = 0;
    logic rst = 1;
    logic [15:0] cpu_addr = 0;
    logic cpu_re = 0;
    logic cpu_we = 0;
    logic [7:0] cpu_wdata = 0;
    logic [7:0] cpu_rdata, mem_wdata, mem_rdata;
    logic cpu_stall, mem_re, mem_we, dma_active;
    logic [15:0] mem_addr;

    logic [7:0] sram [65536];
    logic [7:0] ref_mem [65536];
    int checks = 0;
    int passed = 0;
    bit mon_en = 0;

    // Reference: a transfer is a step count k; steps below SD are delay, then byte (k-SD)/2, even=read, odd=write
    bit act = 0;
    logic [7:0] pg = 0;
    logic [7:0] lat = 0;
    int k = 0;

    oam_dma_arbiter dut (
        .clk(clk), .rst(rst), .cpu_addr(cpu_addr), .cpu_re(cpu_re), .cpu_we(cpu_we),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .dma_active(dma_active)
    );

    always #5 clk = ~clk;
    assign mem_rdata = sram[mem_addr];
    always @(posedge clk) if (mem_we) sram[mem_addr] <= mem_wdata;

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a === e) passed++;
        else $display("FAIL %s: got %0h expected %0h", nm, a, e);
    endtask

    function automatic bit own_now();
        bit acc = cpu_re || cpu_we;
        bit prio = (cpu_addr >= 16'hFF80 && cpu_addr <= 16'hFFFE) || cpu_addr == 16'hFF46;
        return act && k >= SD && !rst && !(acc && prio);
    endfunction

    function automatic bit stall_on();
`ifdef DMA_CPU_STALL_EN
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    always @(posedge clk) begin : model
        bit own;
        int b;
        own = own_now();
        b = (k - SD) / 2;
        if (!own && cpu_we && cpu_addr != 16'hFF46) ref_mem[cpu_addr] = cpu_wdata;
        if (rst) begin
            act = 0;
            pg = 8'h00;
            k = 0;
        end else if (cpu_we && cpu_addr == 16'hFF46) begin
            pg = cpu_wdata;
            act = 1;
            k = 0;
        end else if (act && (k < SD || own)) begin
            if (k >= SD) begin
                if (((k - SD) % 2) == 0) lat = ref_mem[{pg, 8'(b)}];
                else begin
                    ref_mem[{8'hFE, 8'(b)}] = lat;
                    if (b == LEN - 1) act = 0;
                end
            end
            k++;
        end
    end

    always @(negedge clk) begin : mon
        bit own, rd, regh;
        int b;
        if (mon_en) begin
            own = own_now();
            rd = ((k - SD) % 2) == 0;
            b = (k - SD) / 2;
            regh = cpu_addr == 16'hFF46;
            chk("dma_active", dma_active, act);
            chk("cpu_stall", cpu_stall, stall_on() && own && (cpu_re || cpu_we));
            if (own) begin
                chk("dma mem_re", mem_re, rd);
                chk("dma mem_we", mem_we, !rd);
                chk("dma mem_addr", mem_addr, rd ? {pg, 8'(b)} : {8'hFE, 8'(b)});
                if (!rd) chk("dma mem_wdata", mem_wdata, lat);
                if (cpu_re && !stall_on()) chk("blocked cpu_rdata", cpu_rdata, 8'hFF);
            end else begin
                chk("pass mem_re", mem_re, cpu_re && !regh);
                chk("pass mem_we", mem_we, cpu_we && !regh);
                if ((cpu_re || cpu_we) && !regh) chk("pass mem_addr", mem_addr, cpu_addr);
                if (cpu_we && !regh) chk("pass mem_wdata", mem_wdata, cpu_wdata);
                if (cpu_re) chk("pass cpu_rdata", cpu_rdata, regh ? pg : ref_mem[cpu_addr]);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic re, input logic we, input logic [15:0] a, input logic [7:0] d);
        cpu_re = re;
        cpu_we = we;
        cpu_addr = a;
        cpu_wdata = d;
    endtask

    task automatic idle();
        drive(0, 0, 16'h0000, 8'h00);
    endtask

    task automatic poke(input logic [15:0] a, input logic [7:0] d);
        sram[a] = d;
        ref_mem[a] = d;
    endtask

    task automatic start_copy(input logic [7:0] p);
        drive(0, 1, 16'hFF46, p);
        step();
        idle();
    endtask

    initial begin
        int n, errs;
        logic [7:0] v;
        for (int i = 0; i < 65536; i++) begin
            v = 8'($urandom);
            sram[i] = v;
            ref_mem[i] = v;
        end
        step();
        step();
        rst = 0;
        mon_en = 1;
        #1;
        chk("reset dma_active", dma_active, 0);
        chk("reset cpu_stall", cpu_stall, 0);
        drive(1, 0, 16'hFF46, 0);
        #1;
        chk("reset page", cpu_rdata, 8'h00);
        step();

        poke(16'hC000, 8'h5A);
        drive(1, 0, 16'hC000, 0);
        #1;
        chk("idle read C000", cpu_rdata, 8'h5A);
        step();
        drive(0, 1, 16'hC001, 8'h33);
        step();
        idle();
        chk("idle write C001", sram[16'hC001], 8'h33);

        for (int i = 0; i < LEN; i++) poke(16'hC000 + 16'(i), 8'(i) ^ 8'hA5);
        start_copy(8'hC0);
        chk("dma rise", dma_active, 1);
        n = 0;
        while (dma_active && n < 1000) begin
            step();
            n++;
        end
        chk("full copy length", n, 321);
        errs = 0;
        for (int i = 0; i < LEN; i++) if (sram[16'hFE00 + 16'(i)] !== (8'(i) ^ 8'hA5)) errs++;
        chk("full copy contents errors", errs, 0);
        drive(1, 0, 16'hFF46, 0);
        #1;
        chk("page readback", cpu_rdata, 8'hC0);
        step();
        idle();

        poke(16'hC100, 8'h12);
        poke(16'hFF85, 8'h99);
        poke(16'h0150, 8'h3C);
        start_copy(8'hC0);
        n = 0;
        while (dma_active && n < 1000) begin
            idle();
            if (n == 30) drive(1, 0, 16'hFF85, 0);
            if (n == 40) drive(1, 0, 16'h0100, 0);
            if (n == 45) drive(0, 1, 16'hC100, 8'h77);
`ifdef DMA_CPU_STALL_EN
            if (n >= 50) drive(1, 0, 16'h0150, 0);
`endif
            #1;
            if (n == 30) chk("hram read FF85", cpu_rdata, 8'h99);
`ifdef DMA_CPU_STALL_EN
            if (n == 40) chk("blocked read stalls", cpu_stall, 1);
            if (n == 50) chk("held read stalls", cpu_stall, 1);
`else
            if (n == 40) chk("blocked read 0100", cpu_rdata, 8'hFF);
`endif
            step();
            n++;
        end
        chk("copy length with one hram access", n, 322);
        chk("blocked write C100 dropped", sram[16'hC100], 8'h12);
`ifdef DMA_CPU_STALL_EN
        drive(1, 0, 16'h0150, 0);
        #1;
        chk("stalled read completes", cpu_rdata, 8'h3C);
        chk("stall released", cpu_stall, 0);
        step();
`endif
        idle();

        for (int i = 0; i < LEN; i++) poke(16'hD000 + 16'(i), 8'(i) + 8'h03);
        start_copy(8'hC0);
        n = 0;
        while (dma_active && n < 1000) begin
            idle();
            if (n == 81) drive(0, 1, 16'hFF46, 8'hD0);
            step();
            n++;
        end
        idle();
        chk("restart total length", n, 403);
        errs = 0;
        for (int i = 0; i < LEN; i++) if (sram[16'hFE00 + 16'(i)] !== (8'(i) + 8'h03)) errs++;
        chk("restart contents errors", errs, 0);

        for (int i = 0; i < LEN; i++) poke(16'hFE00 + 16'(i), 8'hEE);
        start_copy(8'hC0);
        for (int i = 0; i < 21; i++) step();
        rst = 1;
        step();
        rst = 0;
        chk("reset abort dma_active", dma_active, 0);
        drive(1, 0, 16'hFF46, 0);
        #1;
        chk("reset abort page", cpu_rdata, 8'h00);
        step();
        idle();
        for (int i = 0; i < 20; i++) step();
        errs = 0;
        for (int i = 0; i < 10; i++) if (sram[16'hFE00 + 16'(i)] !== (8'(i) ^ 8'hA5)) errs++;
        chk("reset abort copied head", errs, 0);
        errs = 0;
        for (int i = 10; i < LEN; i++) if (sram[16'hFE00 + 16'(i)] !== 8'hEE) errs++;
        chk("reset abort untouched tail", errs, 0);

        for (int c = 0; c < 4000; c++) begin
            int r, s;
            idle();
            rst = 0;
            r = $urandom_range(0, 999);
            s = $urandom_range(0, 3);
            if (r < 3) rst = 1;
            else if (r < 12) drive(0, 1, 16'hFF46, 8'($urandom));
            else if (r < 600) begin
                logic [15:0] a;
                bit w;
                a = (s == 0) ? 16'hFF80 + 16'($urandom_range(0, 127)) :
                    (s == 1) ? 16'($urandom) :
                    (s == 2) ? 16'hFE00 + 16'($urandom_range(0, 255)) : 16'hFF46;
                w = (s != 3) && $urandom_range(0, 1) == 1;
                drive(!w, w, a, 8'($urandom));
            end
            step();
        end
        rst = 0;
        idle();
        n = 0;
        while (dma_active && n < 1000) begin
            step();
            n++;
        end
        chk("random phase ends idle", dma_active, 0);
        errs = 0;
        for (int i = 0; i < 65536; i++) if (sram[i] !== ref_mem[i]) errs++;
        chk("sram vs model errors", errs, 0);
        mon_en = 0;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
